// File: rtl/video_scanout_timing_pkg.sv
// Shared raster timing constants, framebuffer bases and counter widths for the scanout path.
// The GPU write side uses the same buffer bases.
package video_scanout_timing_pkg;
  localparam int CNT_W = 11;
  localparam int DEF_ADDR_W = 24;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_SCALE    = 2;
  localparam int DEF_LEAD     = 3;

  localparam int FB_BASE0 = 0;
  localparam int FB_BASE1 = 76800;

  function automatic int hTotal(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int vTotal(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/video_scanout_timing_raster_counter.sv
// (h,v) raster position counter with a configurable reset position.
// lineWrap/frameWrap flag the last position of a line / of a frame.
module raster_counter
  import video_scanout_timing_pkg::*;
#(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int H_RST   = 0,
  parameter int V_RST   = 0
)(
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             lineWrap,
  output logic             frameWrap
);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_INIT = CNT_W'(H_RST);
  localparam logic [CNT_W-1:0] V_INIT = CNT_W'(V_RST);

  assign lineWrap  = (h == H_LAST);
  assign frameWrap = lineWrap && (v == V_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h <= H_INIT;
      v <= V_INIT;
    end else if (lineWrap) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end
endmodule

// File: rtl/video_scanout_timing.sv
// HDMI raster timing plus framebuffer read addressing, issued LEAD cycles ahead of display
// with nearest-neighbour upscaling. Buffer select is latched once per frame to avoid tearing.
module video_scanout_timing
  import video_scanout_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SCALE    = DEF_SCALE,
  parameter int FB_BASE0 = video_scanout_timing_pkg::FB_BASE0,
  parameter int FB_BASE1 = video_scanout_timing_pkg::FB_BASE1,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LEAD     = DEF_LEAD
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              fbHDMI,
  output logic              hSync,
  output logic              vSync,
  output logic              de,
  output logic [CNT_W-1:0]  pixelX,
  output logic [CNT_W-1:0]  pixelY,
  output logic              frameStart,
  output logic              fbRead,
  output logic [ADDR_W-1:0] fbAddr
);
  localparam int HT = hTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = vTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0]  HA      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  HA_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0]  HS_ON   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0]  HS_OFF  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0]  VA      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0]  VS_ON   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0]  VS_OFF  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0]  SMASK   = CNT_W'(SCALE - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE / SCALE);
  localparam logic [ADDR_W-1:0] BASE0   = ADDR_W'(FB_BASE0);
  localparam logic [ADDR_W-1:0] BASE1   = ADDR_W'(FB_BASE1);

  logic [CNT_W-1:0]  fh, fv, dh, dv;
  logic              fLineWrap, fFrameWrap;
  logic              dispLineWrapUnused, dispFrameWrapUnused;
  logic              bufSel;
  logic [CNT_W-1:0]  col;
  logic [ADDR_W-1:0] rowBase;
  logic              fetchActive, dispActive;

  raster_counter #(.H_TOTAL(HT), .V_TOTAL(VT), .H_RST(0), .V_RST(0)) fetchCnt (
    .clk(clk), .reset(reset), .h(fh), .v(fv),
    .lineWrap(fLineWrap), .frameWrap(fFrameWrap)
  );

  // Display trails the fetch by exactly LEAD positions, including across frame wrap.
  raster_counter #(.H_TOTAL(HT), .V_TOTAL(VT), .H_RST(HT - LEAD), .V_RST(VT - 1)) dispCnt (
    .clk(clk), .reset(reset), .h(dh), .v(dv),
    .lineWrap(dispLineWrapUnused), .frameWrap(dispFrameWrapUnused)
  );

  assign fetchActive = (fh < HA) && (fv < VA);
  assign dispActive  = (dh < HA) && (dv < VA);

  // col and rowBase track fh/SCALE and (fv/SCALE)*(H_ACTIVE/SCALE) for the current fetch position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bufSel  <= 1'b0;
      col     <= '0;
      rowBase <= '0;
    end else begin
      if (fFrameWrap) bufSel <= fbHDMI;
      if (fLineWrap) col <= '0;
      else if ((fh & SMASK) == SMASK) col <= col + 1'b1;
      if (fFrameWrap) rowBase <= '0;
      else if (fh == HA_LAST && fv < VA && (fv & SMASK) == SMASK) rowBase <= rowBase + ROW_STEP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hSync      <= 1'b0;
      vSync      <= 1'b0;
      de         <= 1'b0;
      pixelX     <= '0;
      pixelY     <= '0;
      frameStart <= 1'b0;
      fbRead     <= 1'b0;
      fbAddr     <= '0;
    end else begin
      hSync      <= (dh >= HS_ON) && (dh < HS_OFF);
      vSync      <= (dv >= VS_ON) && (dv < VS_OFF);
      de         <= dispActive;
      pixelX     <= dispActive ? dh : '0;
      pixelY     <= dispActive ? dv : '0;
      frameStart <= (dh == '0) && (dv == '0);
      fbRead     <= fetchActive;
      fbAddr     <= fetchActive ? ((bufSel ? BASE1 : BASE0) + rowBase + ADDR_W'(col)) : '0;
    end
  end
endmodule
